load_path_ctrl: RTL and testbench

Sequences every data-side load in the RISC-V core's MEM/WB path. It decodes the load address into the BIOS, DMEM or memory-mapped IO region and drives the read enable for that target. It tracks the one-cycle synchronous-read latency of BIOS/DMEM and runs a stalling request/acknowledge handshake for variable-latency IO reads. It returns one aligned, sign- or zero-extended word per load to writeback.

---
 rtl/load_path_pkg.sv | 55 +++++
 rtl/load_path_ctrl_if.sv | 43 ++++
 rtl/load_extract.sv | 39 +++
 rtl/load_path_ctrl.sv | 172 +++++++++++++++++
 tb/tb_load_path_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_path_pkg.sv
// load_path_pkg: shared types and constants for the MEM/WB load path.
// Region, state and funct3 encodings plus the region/alignment helpers.
package load_path_pkg;

   typedef enum logic [1:0] {
      REG_DMEM,
      REG_BIOS,
      REG_IO
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM_RSP,
      ST_IO_WAIT,
      ST_IO_RSP
   } state_e;

   localparam logic [3:0] NIB_DMEM_A = 4'b0001;
   localparam logic [3:0] NIB_DMEM_B = 4'b0011;
   localparam logic [3:0] NIB_BIOS   = 4'b0100;
   localparam logic [3:0] NIB_IO     = 4'b1000;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [31:0] IO_TIMEOUT_DATA = 32'hDEAD_BEEF;

   // Unlisted nibbles land in DMEM, same as the two DMEM nibbles.
   function automatic region_e decode_region(input logic [3:0] nib);
      region_e r;
      case (nib)
         NIB_BIOS:   r = REG_BIOS;
         NIB_IO:     r = REG_IO;
         NIB_DMEM_A: r = REG_DMEM;
         NIB_DMEM_B: r = REG_DMEM;
         default:    r = REG_DMEM;
      endcase
      return r;
   endfunction

   function automatic logic is_misaligned(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic word_bad;
      logic half_bad;
      word_bad = (f3 == F3_LW) && (off != 2'b00);
      half_bad = ((f3 == F3_LH) || (f3 == F3_LHU)) && off[0];
      return word_bad || half_bad;
   endfunction

endpackage

// File: rtl/load_path_ctrl_if.sv
// load_path_if: load request/response, BIOS/DMEM and IO read signals.
// master = MEM stage and memories, slave = load_path_ctrl.
interface load_path_if;

   logic        req_valid;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;

   logic        bios_en;
   logic        dmem_en;
   logic [13:0] mem_addr;
   logic [31:0] bios_doutb;
   logic [31:0] dmem_dout;

   logic        io_rd_valid;
   logic [31:0] io_rd_addr;
   logic        io_rd_ack;
   logic [31:0] io_dout;

   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        err;

   modport master (
      output req_valid, req_addr, req_funct3,
      output bios_doutb, dmem_dout,
      output io_rd_ack, io_dout,
      input  bios_en, dmem_en, mem_addr,
      input  io_rd_valid, io_rd_addr,
      input  stall, rsp_valid, rsp_data, err
   );

   modport slave (
      input  req_valid, req_addr, req_funct3,
      input  bios_doutb, dmem_dout,
      input  io_rd_ack, io_dout,
      output bios_en, dmem_en, mem_addr,
      output io_rd_valid, io_rd_addr,
      output stall, rsp_valid, rsp_data, err
   );

endinterface

// File: rtl/load_extract.sv
// load_extract: picks the byte/half/word at the load offset.
// LB/LH sign-extend, LBU/LHU zero-extend, anything else passes the word.
module load_extract
   import load_path_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  f3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      unique case (off_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = 8'h00;
      endcase
   end

   assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

   always_comb begin
      data_o = word_i;
      case (f3_i)
         F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  data_o = {24'h000000, byte_sel};
         F3_LHU:  data_o = {16'h0000, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_path_ctrl.sv
// load_path_ctrl: MEM/WB load sequencer for BIOS, DMEM and IO reads.
// Define LOAD_IO_TIMEOUT_EN to abandon IO reads after IO_TIMEOUT_CYCLES.
module load_path_ctrl
   import load_path_pkg::*;
#(
   parameter int unsigned IO_TIMEOUT_CYCLES = 255
) (
   input logic        clk,
   input logic        rst_n,
   load_path_if.slave bus
);

   state_e      state_q, state_d;
   region_e     region_q, region_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        merr_q, merr_d;
   logic [31:0] io_addr_q, io_addr_d;
   logic [31:0] io_data_q, io_data_d;

`ifdef LOAD_IO_TIMEOUT_EN
   localparam int CNT_W = $clog2(IO_TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(IO_TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^IO_TIMEOUT_CYCLES;
`endif

   region_e     req_region;
   logic        req_mis;
   logic        acc;
   logic        acc_io;
   logic        acc_mem;
   logic [31:0] ext_word;
   logic [31:0] ext_data;
   logic [31:0] rsp_data;
   logic        rsp_err;

   assign req_region = decode_region(bus.req_addr[31:28]);
   assign req_mis    = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);

   // Every state except IO_WAIT can take a new load in the same cycle.
   assign acc     = bus.req_valid && (state_q != ST_IO_WAIT);
   assign acc_io  = acc && !req_mis && (req_region == REG_IO);
   assign acc_mem = acc && !req_mis && (req_region != REG_IO);

   always_comb begin
      state_d   = state_q;
      region_d  = region_q;
      off_d     = off_q;
      f3_d      = f3_q;
      merr_d    = merr_q;
      io_addr_d = io_addr_q;
      io_data_d = io_data_q;
`ifdef LOAD_IO_TIMEOUT_EN
      cnt_d     = cnt_q;
      to_d      = to_q;
`endif
      unique case (state_q)
         ST_IO_WAIT: begin
`ifdef LOAD_IO_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (bus.io_rd_ack) begin
               io_data_d = bus.io_dout;
               state_d   = ST_IO_RSP;
            end
`ifdef LOAD_IO_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               to_d    = 1'b1;
               state_d = ST_IO_RSP;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            if (acc) begin
               region_d = req_region;
               off_d    = bus.req_addr[1:0];
               f3_d     = bus.req_funct3;
               merr_d   = req_mis;
`ifdef LOAD_IO_TIMEOUT_EN
               cnt_d    = '0;
               to_d     = 1'b0;
`endif
               if (acc_io) begin
                  io_addr_d = bus.req_addr;
                  state_d   = ST_IO_WAIT;
               end else begin
                  state_d   = ST_MEM_RSP;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         region_q  <= REG_DMEM;
         off_q     <= 2'b00;
         f3_q      <= 3'b000;
         merr_q    <= 1'b0;
         io_addr_q <= '0;
         io_data_q <= '0;
`ifdef LOAD_IO_TIMEOUT_EN
         cnt_q     <= '0;
         to_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         region_q  <= region_d;
         off_q     <= off_d;
         f3_q      <= f3_d;
         merr_q    <= merr_d;
         io_addr_q <= io_addr_d;
         io_data_q <= io_data_d;
`ifdef LOAD_IO_TIMEOUT_EN
         cnt_q     <= cnt_d;
         to_q      <= to_d;
`endif
      end
   end

   always_comb begin
      ext_word = bus.dmem_dout;
      if (state_q == ST_IO_RSP) begin
         ext_word = io_data_q;
      end else if (region_q == REG_BIOS) begin
         ext_word = bus.bios_doutb;
      end
   end

   load_extract u_extract (
      .word_i (ext_word),
      .off_i  (off_q),
      .f3_i   (f3_q),
      .data_o (ext_data)
   );

   always_comb begin
      rsp_data = '0;
      rsp_err  = 1'b0;
      if (state_q == ST_MEM_RSP) begin
         rsp_err  = merr_q;
         rsp_data = merr_q ? 32'h0 : ext_data;
      end else if (state_q == ST_IO_RSP) begin
`ifdef LOAD_IO_TIMEOUT_EN
         rsp_err  = to_q;
         rsp_data = to_q ? IO_TIMEOUT_DATA : ext_data;
`else
         rsp_data = ext_data;
`endif
      end
   end

   assign bus.bios_en     = acc_mem && (req_region == REG_BIOS);
   assign bus.dmem_en     = acc_mem && (req_region == REG_DMEM);
   assign bus.mem_addr    = bus.req_addr[15:2];
   assign bus.io_rd_valid = (state_q == ST_IO_WAIT);
   assign bus.io_rd_addr  = io_addr_q;
   assign bus.stall       = (state_q == ST_IO_WAIT) || acc_io;
   assign bus.rsp_valid   = (state_q == ST_MEM_RSP) ||
                            (state_q == ST_IO_RSP);
   assign bus.rsp_data    = rsp_data;
   assign bus.err         = rsp_err;

endmodule

// File: tb/tb_load_path_ctrl.sv
// tb_load_path_ctrl: directed and randomized loads against a reference model.
// Memories answer with a word chosen per load; IO ack timing is driven inline.
module tb_load_path_ctrl;
   import load_path_pkg::*;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   load_path_if bus ();

   load_path_ctrl #(.IO_TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] nxt_bios = 32'h0;
   logic [31:0] nxt_dmem = 32'h0;

   always @(posedge clk) begin
      if (bus.bios_en) bus.bios_doutb <= nxt_bios;
      if (bus.dmem_en) bus.dmem_dout <= nxt_dmem;
   end

   bit          pend_v = 0;
   logic [31:0] pend_d = 32'h0;
   bit          pend_e = 0;

   // 0 = DMEM, 1 = BIOS, 2 = IO
   function automatic int region_of(input logic [31:0] a);
      int nib;
      nib = int'(a >> 28);
      if (nib == 4) return 1;
      if (nib == 8) return 2;
      return 0;
   endfunction

   function automatic bit mis_of(input logic [31:0] a, input logic [2:0] f3);
      int unsigned off;
      off = a % 4;
      if (f3 == F3_LW) return off != 0;
      if (f3 == F3_LH || f3 == F3_LHU) return (off % 2) != 0;
      return 0;
   endfunction

   function automatic logic [31:0] ref_load(
      input logic [31:0] w,
      input logic [31:0] a,
      input logic [2:0]  f3
   );
      int unsigned off, b, h;
      off = a % 4;
      b = (w >> (8 * off)) % 256;
      h = (w >> (16 * (off / 2))) % 65536;
      case (f3)
         F3_LB:  return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
         F3_LH:  return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
         F3_LBU: return 32'(b);
         F3_LHU: return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [2:0] rand_f3();
      int k;
      k = $urandom_range(0, 4);
      case (k)
         0: return F3_LB;
         1: return F3_LH;
         2: return F3_LW;
         3: return F3_LBU;
         default: return F3_LHU;
      endcase
   endfunction

   // One BIOS/DMEM (or misaligned) cycle; also checks the previous response.
   task automatic mem_step(
      input bit          v,
      input logic [31:0] a,
      input logic [2:0]  f3,
      input logic [31:0] w,
      input string       tag
   );
      bit mis, eb, ed;
      int r;
      @(posedge clk); #1;
      bus.req_valid  = v;
      bus.req_addr   = a;
      bus.req_funct3 = f3;
      r   = region_of(a);
      mis = mis_of(a, f3);
      if (r == 1) nxt_bios = w;
      else nxt_dmem = w;
      eb = v && !mis && r == 1;
      ed = v && !mis && r == 0;
      @(negedge clk);
      checks++;
      if (bus.bios_en !== eb) begin
         errors++;
         $display("FAIL %s bios_en got %b exp %b", tag, bus.bios_en, eb);
      end
      checks++;
      if (bus.dmem_en !== ed) begin
         errors++;
         $display("FAIL %s dmem_en got %b exp %b", tag, bus.dmem_en, ed);
      end
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL %s stall got %b exp 0", tag, bus.stall);
      end
      if (v) begin
         checks++;
         if (bus.mem_addr !== a[15:2]) begin
            errors++;
            $display("FAIL %s mem_addr got %h exp %h", tag, bus.mem_addr, a[15:2]);
         end
      end
      checks++;
      if (bus.rsp_valid !== pend_v) begin
         errors++;
         $display("FAIL %s rsp_valid got %b exp %b", tag, bus.rsp_valid, pend_v);
      end
      if (pend_v) begin
         checks++;
         if (bus.rsp_data !== pend_d) begin
            errors++;
            $display("FAIL %s rsp_data got %h exp %h", tag, bus.rsp_data, pend_d);
         end
         checks++;
         if (bus.err !== pend_e) begin
            errors++;
            $display("FAIL %s err got %b exp %b", tag, bus.err, pend_e);
         end
      end
      pend_v = v;
      pend_e = v && mis;
      pend_d = (v && !mis) ? ref_load(w, a, f3) : 32'h0;
   endtask

   // IO load; ack arrives in the waits-th IO_WAIT cycle.
   task automatic io_load(
      input logic [31:0] a,
      input logic [2:0]  f3,
      input int          waits,
      input logic [31:0] d,
      input string       tag
   );
      int stalls;
      logic [31:0] exp;
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_addr   = a;
      bus.req_funct3 = f3;
      bus.io_rd_ack  = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1 || bus.bios_en !== 1'b0 || bus.dmem_en !== 1'b0) begin
         errors++;
         $display("FAIL %s accept stall/en got %b%b%b exp 100", tag,
                  bus.stall, bus.bios_en, bus.dmem_en);
      end
      checks++;
      if (bus.rsp_valid !== pend_v) begin
         errors++;
         $display("FAIL %s prev rsp_valid got %b exp %b", tag, bus.rsp_valid, pend_v);
      end
      if (pend_v) begin
         checks++;
         if (bus.rsp_data !== pend_d || bus.err !== pend_e) begin
            errors++;
            $display("FAIL %s prev rsp got %h/%b exp %h/%b", tag,
                     bus.rsp_data, bus.err, pend_d, pend_e);
         end
      end
      pend_v = 0;
      stalls = (bus.stall === 1'b1) ? 1 : 0;
      for (int i = 1; i <= waits; i++) begin
         @(posedge clk); #1;
         bus.req_valid  = 1'($urandom_range(0, 1));
         bus.req_addr   = $urandom;
         bus.req_funct3 = rand_f3();
         bus.io_rd_ack  = (i == waits);
         bus.io_dout    = (i == waits) ? d : $urandom;
         @(negedge clk);
         if (bus.stall === 1'b1) stalls++;
         checks++;
         if (bus.io_rd_valid !== 1'b1 || bus.io_rd_addr !== a) begin
            errors++;
            $display("FAIL %s wait%0d io_rd got %b/%h exp 1/%h", tag, i,
                     bus.io_rd_valid, bus.io_rd_addr, a);
         end
         checks++;
         if (bus.bios_en !== 1'b0 || bus.dmem_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s wait%0d en/rsp got %b%b%b exp 000", tag, i,
                     bus.bios_en, bus.dmem_en, bus.rsp_valid);
         end
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.io_rd_ack = 1'b1;
      bus.io_dout   = $urandom;
      exp = ref_load(d, a, f3);
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL %s rsp got %b/%h/%b exp 1/%h/0", tag,
                  bus.rsp_valid, bus.rsp_data, bus.err, exp);
      end
      checks++;
      if (bus.stall !== 1'b0 || bus.io_rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s rsp stall/io_rd_valid got %b%b exp 00", tag,
                  bus.stall, bus.io_rd_valid);
      end
      checks++;
      if (stalls != waits + 1) begin
         errors++;
         $display("FAIL %s stall_cycles got %0d exp %0d", tag, stalls, waits + 1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.bios_en, bus.dmem_en, bus.io_rd_valid, bus.stall,
           bus.rsp_valid, bus.err} !== 6'b0) begin
         errors++;
         $display("FAIL reset flags got %b%b%b%b%b%b exp 000000",
                  bus.bios_en, bus.dmem_en, bus.io_rd_valid, bus.stall,
                  bus.rsp_valid, bus.err);
      end
      checks++;
      if (bus.io_rd_addr !== 32'h0 || bus.rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL reset data got %h/%h exp 0/0", bus.io_rd_addr, bus.rsp_data);
      end
      @(posedge clk); #1;
      rst_n  = 1'b1;
      pend_v = 0;
   endtask

   task automatic test_lw_dmem();
      mem_step(1, 32'h1000_0008, F3_LW, 32'h8765_4321, "lw_dmem");
      mem_step(0, 32'h0, F3_LW, 32'h0, "lw_dmem_rsp");
   endtask

   task automatic test_lb_bios();
      mem_step(1, 32'h4000_0003, F3_LB, 32'h80FF_FFFF, "lb_bios");
      mem_step(1, 32'h4000_0003, F3_LBU, 32'h80FF_FFFF, "lbu_bios");
      mem_step(0, 32'h0, F3_LW, 32'h0, "lbu_bios_rsp");
   endtask

   task automatic test_back_to_back();
      mem_step(1, 32'h1000_0002, F3_LH, 32'hBEEF_0000, "b2b_lh");
      mem_step(1, 32'h3000_0000, F3_LHU, 32'h0000_9ABC, "b2b_lhu");
      mem_step(0, 32'h0, F3_LW, 32'h0, "b2b_rsp");
   endtask

   task automatic test_io_ack();
      io_load(32'h8000_0010, F3_LW, 4, 32'h0000_0042, "io_ack4");
      io_load(32'h8000_0123, F3_LB, 1, 32'h8100_0000, "io_ack1");
   endtask

   task automatic test_misaligned();
      mem_step(1, 32'h1000_0001, F3_LW, 32'hFFFF_FFFF, "mis_lw");
      mem_step(1, 32'h4000_0003, F3_LHU, 32'hFFFF_FFFF, "mis_lhu");
      mem_step(1, 32'h8000_0002, F3_LW, 32'hFFFF_FFFF, "mis_io");
      mem_step(0, 32'h0, F3_LW, 32'h0, "mis_rsp");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [2:0]  f3;
      for (int i = 0; i < 60; i++) begin
         a  = $urandom;
         f3 = rand_f3();
         if ($urandom_range(0, 5) == 0) begin
            a[31:28] = 4'h8;
            a[1:0]   = 2'b00;
            io_load(a, f3, $urandom_range(1, 5), $urandom, "rand_io");
         end else begin
            if (a[31:28] == 4'h8 && !mis_of(a, f3)) a[31:28] = 4'h4;
            mem_step(1'($urandom_range(0, 3) != 0), a, f3, $urandom, "rand_mem");
         end
      end
      mem_step(0, 32'h0, F3_LW, 32'h0, "rand_drain");
   endtask

   task automatic test_io_no_ack();
      io_load_start(32'h8000_0200);
`ifdef LOAD_IO_TIMEOUT_EN
      for (int i = 1; i < TO; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (bus.io_rd_valid !== 1'b1 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL timeout wait%0d got %b%b exp 11", i,
                     bus.io_rd_valid, bus.stall);
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDEAD_BEEF || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL timeout rsp got %b/%h/%b exp 1/deadbeef/1",
                  bus.rsp_valid, bus.rsp_data, bus.err);
      end
      checks++;
      if (bus.io_rd_valid !== 1'b0 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL timeout release got %b%b exp 00", bus.io_rd_valid, bus.stall);
      end
`else
      repeat (3 * TO) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.io_rd_valid !== 1'b1 || bus.stall !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_ack hold got %b%b%b exp 110", bus.io_rd_valid,
                  bus.stall, bus.rsp_valid);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
`endif
      pend_v = 0;
   endtask

   task automatic io_load_start(input logic [31:0] a);
      @(posedge clk); #1;
      bus.req_valid  = 1'b1;
      bus.req_addr   = a;
      bus.req_funct3 = F3_LW;
      bus.io_rd_ack  = 1'b0;
      @(posedge clk); #1;
      bus.req_valid  = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.io_rd_valid !== 1'b1 || bus.io_rd_addr !== a) begin
         errors++;
         $display("FAIL io_start got %b/%h exp 1/%h", bus.io_rd_valid, bus.io_rd_addr, a);
      end
   endtask

   task automatic test_io_reset();
      io_load_start(32'h8000_0040);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.io_rd_valid !== 1'b1) begin
         errors++;
         $display("FAIL io_reset pre-edge io_rd_valid got %b exp 1", bus.io_rd_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({bus.io_rd_valid, bus.stall, bus.rsp_valid, bus.err} !== 4'b0 ||
          bus.rsp_data !== 32'h0 || bus.io_rd_addr !== 32'h0) begin
         errors++;
         $display("FAIL io_reset outputs got %b%b%b%b/%h/%h exp 0000/0/0",
                  bus.io_rd_valid, bus.stall, bus.rsp_valid, bus.err,
                  bus.rsp_data, bus.io_rd_addr);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.io_rd_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b0 || bus.io_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL io_reset after%0d got %b%b exp 00", i,
                     bus.rsp_valid, bus.io_rd_valid);
         end
         @(posedge clk); #1;
      end
      bus.io_rd_ack = 1'b0;
      pend_v = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_funct3 = 3'b000;
      bus.io_rd_ack  = 1'b0;
      bus.io_dout    = 32'h0;
      test_reset();
      test_lw_dmem();
      test_lb_bios();
      test_back_to_back();
      test_io_ack();
      test_misaligned();
      test_random();
      test_io_no_ack();
      test_io_reset();
      mem_step(1, 32'h1000_0004, F3_LW, 32'h1234_5678, "post_reset");
      mem_step(0, 32'h0, F3_LW, 32'h0, "post_reset_rsp");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
